// File: rtl/ctrl_exec_pkg.sv
// Shared types and constants for the run-control stage (controle_execucao).
// The state encoding is also what appears on the board LEDs.
package ctrl_exec_pkg;

  typedef enum logic [1:0] {
    ST_PARADO = 2'd0,
    ST_EXEC   = 2'd1,
    ST_PASSO  = 2'd2,
    ST_HALT   = 2'd3
  } estado_t;

  // 10 ms of stable input at 50 MHz before a debounced level may change
  localparam int DEB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stable-sample counter.
// The output only moves after DEB_CYCLES consecutive synchronized samples
// disagree with it; any agreeing sample restarts the count.
// RST_VAL is the idle level the output and synchronizer take in reset.
module debounce #(
  parameter int   DEB_CYCLES = 500000,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clock_fpga,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_count;

  // Synchronize the raw input, then accept a new level only after it has been stable long enough
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
      r_db    <= RST_VAL;
      r_count <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_count <= '0;
      end else if (r_count == LAST) begin
        r_db    <= r_sync2;
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/controle_execucao.sv
// Run-control stage feeding the frequency divider: debounces the step key
// and run switch, follows the CPU HLT level and drives congela/halt.
// Modes: free run, frozen, and single step (one new_clock tick per press).
// Optional feature macro: CYCLE_COUNT_EN -- when defined, ciclos counts the
// ticks delivered to the CPU; otherwise ciclos is tied to zero.
module controle_execucao
  import ctrl_exec_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             clock_fpga,
  input  logic             reset_n,
  input  logic             key_passo,
  input  logic             sw_exec,
  input  logic             halt_cpu,
  input  logic             new_clock,
  output logic             congela,
  output logic             halt,
  output logic [1:0]       led_estado,
  output logic [CNT_W-1:0] ciclos
);

  logic    w_key_db;
  logic    w_sw_db;
  logic    w_passo_pulse;
  logic    r_key_prev;
  estado_t r_state;
  logic    r_congela;
  logic    r_halt;

  // Step key idles high (active-low button), run switch idles low
  debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .RST_VAL   (1'b1)
  ) u_deb_passo (
    .clock_fpga(clock_fpga),
    .reset_n   (reset_n),
    .i_raw     (key_passo),
    .o_db      (w_key_db)
  );

  debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .RST_VAL   (1'b0)
  ) u_deb_exec (
    .clock_fpga(clock_fpga),
    .reset_n   (reset_n),
    .i_raw     (sw_exec),
    .o_db      (w_sw_db)
  );

  // Remember the previous debounced key level to detect a press edge
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      r_key_prev <= 1'b1;
    end else begin
      r_key_prev <= w_key_db;
    end
  end

  assign w_passo_pulse = r_key_prev & ~w_key_db;

  // Run-control FSM; congela/halt are registered alongside the state
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_PARADO;
      r_congela <= 1'b1;
      r_halt    <= 1'b0;
    end else begin
      case (r_state)
        ST_PARADO: begin
          if (w_sw_db) begin
            r_state   <= ST_EXEC;
            r_congela <= 1'b0;
          end else if (w_passo_pulse) begin
            r_state   <= ST_PASSO;
            r_congela <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (halt_cpu) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
          end else if (!w_sw_db) begin
            r_state   <= ST_PARADO;
            r_congela <= 1'b1;
          end
        end
        ST_PASSO: begin
          if (halt_cpu) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
          end else if (new_clock) begin
            r_state   <= ST_PARADO;
            r_congela <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!w_sw_db) begin
            r_state   <= ST_PARADO;
            r_congela <= 1'b1;
            r_halt    <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_PARADO;
          r_congela <= 1'b1;
          r_halt    <= 1'b0;
        end
      endcase
    end
  end

  assign congela    = r_congela;
  assign halt       = r_halt;
  assign led_estado = r_state;

`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_ciclos;

  // Count ticks actually released to the CPU; a simultaneous HLT wins over the tick
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      r_ciclos <= '0;
    end else if ((r_state == ST_EXEC || r_state == ST_PASSO) && new_clock && !halt_cpu) begin
      r_ciclos <= r_ciclos + CNT_W'(1);
    end
  end

  assign ciclos = r_ciclos;
`else
  assign ciclos = '0;
`endif

endmodule

// File: tb/tb_controle_execucao.sv
// Directed bench for controle_execucao with DEB_CYCLES=4 and CNT_W=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_controle_execucao;

  localparam int DEB = 4;
  localparam int CW  = 4;

  logic          clock_fpga = 1'b0;
  logic          reset_n;
  logic          key_passo;
  logic          sw_exec;
  logic          halt_cpu;
  logic          new_clock;
  logic          congela;
  logic          halt;
  logic [1:0]    led_estado;
  logic [CW-1:0] ciclos;

  int numChecks = 0;
  int numErrors = 0;
  int expCiclos = 0;

  controle_execucao #(
    .DEB_CYCLES(DEB),
    .CNT_W     (CW)
  ) dut (
    .clock_fpga(clock_fpga),
    .reset_n   (reset_n),
    .key_passo (key_passo),
    .sw_exec   (sw_exec),
    .halt_cpu  (halt_cpu),
    .new_clock (new_clock),
    .congela   (congela),
    .halt      (halt),
    .led_estado(led_estado),
    .ciclos    (ciclos)
  );

  // 100 MHz-style free-running clock
  always #5 clock_fpga = ~clock_fpga;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ciclosEsperado();
`ifdef CYCLE_COUNT_EN
    return 32'(expCiclos % 16);
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkState(input string tag, input int led, input int cong, input int hlt);
    checkOutput({tag, ".led"}, 32'(led_estado), 32'(led));
    checkOutput({tag, ".congela"}, 32'(congela), 32'(cong));
    checkOutput({tag, ".halt"}, 32'(halt), 32'(hlt));
    checkOutput({tag, ".ciclos"}, 32'(ciclos), ciclosEsperado());
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock_fpga);
  endtask

  task automatic applyStimulus(input logic key, input logic sw, input logic hc, input logic nc);
    key_passo = key;
    sw_exec   = sw;
    halt_cpu  = hc;
    new_clock = nc;
  endtask

  task automatic pulseTick();
    new_clock = 1'b1;
    @(negedge clock_fpga);
    new_clock = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkState("reset", 0, 1, 0);
    reset_n = 1'b1;

    // Scenario 1: idle for 100 cycles
    for (int i = 0; i < 4; i++) begin
      waitCycles(25);
      checkState("idle", 0, 1, 0);
    end

    // Scenario 2: 3-cycle glitch is filtered, a real press steps once
    key_passo = 1'b0;
    waitCycles(3);
    key_passo = 1'b1;
    waitCycles(10);
    checkState("glitch", 0, 1, 0);

    key_passo = 1'b0;
    waitCycles(6);
    checkState("press.early", 0, 1, 0);
    waitCycles(1);
    checkState("press.passo", 2, 0, 0);
    waitCycles(3);
    key_passo = 1'b1;
    waitCycles(2);
    checkState("passo.wait", 2, 0, 0);
    pulseTick();
    expCiclos++;
    checkState("passo.done", 0, 1, 0);
    waitCycles(10);
    checkState("passo.release", 0, 1, 0);

    // Scenario 3: free run with 5 ticks, then stop
    sw_exec = 1'b1;
    waitCycles(6);
    checkState("run.early", 0, 1, 0);
    waitCycles(1);
    checkState("run.exec", 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      pulseTick();
      expCiclos++;
      waitCycles(1);
    end
    checkState("run.ticks", 1, 0, 0);
    sw_exec = 1'b0;
    waitCycles(6);
    checkState("stop.early", 1, 0, 0);
    waitCycles(1);
    checkState("stop.parado", 0, 1, 0);

    // Scenario 4: HLT beats a simultaneous tick; step and ticks ignored in HALT
    sw_exec = 1'b1;
    waitCycles(7);
    checkState("run2.exec", 1, 0, 0);
    halt_cpu  = 1'b1;
    new_clock = 1'b1;
    @(negedge clock_fpga);
    halt_cpu  = 1'b0;
    new_clock = 1'b0;
    checkState("hlt", 3, 0, 1);
    key_passo = 1'b0;
    waitCycles(10);
    key_passo = 1'b1;
    waitCycles(10);
    checkState("hlt.step", 3, 0, 1);
    pulseTick();
    checkState("hlt.tick", 3, 0, 1);
    sw_exec = 1'b0;
    waitCycles(6);
    checkState("hlt.early", 3, 0, 1);
    waitCycles(1);
    checkState("hlt.exit", 0, 1, 0);

    // Scenario 5: asynchronous reset in the middle of a step
    key_passo = 1'b0;
    waitCycles(7);
    checkState("rst.passo", 2, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    expCiclos = 0;
    checkState("rst.async", 0, 1, 0);
    key_passo = 1'b1;
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(10);
    checkState("rst.after", 0, 1, 0);

    // Scenario 6: tick in PARADO ignored, 17 ticks in run wrap a 4-bit count
    pulseTick();
    checkState("parado.tick", 0, 1, 0);
    sw_exec = 1'b1;
    waitCycles(7);
    checkState("wrap.exec", 1, 0, 0);
    for (int i = 0; i < 17; i++) begin
      pulseTick();
      expCiclos++;
    end
    checkState("wrap.count", 1, 0, 0);
    sw_exec = 1'b0;
    waitCycles(7);
    checkState("wrap.stop", 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
